// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block: FSM state encoding,
// counter width helper and the default saturate/timeout value.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    INACTIVE
  } e_cap_state;

  // Counters need one extra bit so a full 2^TOTAL_BITS period fits.
  function automatic int cap_width(input int total_bits);
    return total_bits + 1;
  endfunction

  localparam int CAP_TOTAL_BITS = 8;
  localparam int CAP_SAT        = (1 << cap_width(CAP_TOTAL_BITS)) - 1;

endpackage

// File: rtl/pwm_edge_sync.sv
// Input conditioning for pwm_capture: 2-FF synchronizer, optional 3-tap
// majority filter (PWM_CAPTURE_FILTER_EN) and registered active/inactive edge pulses.
module pwm_edge_sync #(
  parameter logic POL = 1'b1
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iLine,
  output logic oActEdge,
  output logic oInactEdge
);

  logic sync1_q, sync2_q;
  logic level;
  logic prev_q, act_edge_q, inact_edge_q;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      sync1_q <= POL;
      sync2_q <= POL;
    end else begin
      sync1_q <= iLine;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  logic tap1_q, tap2_q, filt_q;

  // A level must be seen on two of three consecutive samples to pass.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      tap1_q <= POL;
      tap2_q <= POL;
      filt_q <= POL;
    end else begin
      tap1_q <= sync2_q;
      tap2_q <= tap1_q;
      filt_q <= (sync2_q & tap1_q) | (sync2_q & tap2_q) | (tap1_q & tap2_q);
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      prev_q       <= POL;
      act_edge_q   <= 1'b0;
      inact_edge_q <= 1'b0;
    end else begin
      prev_q       <= level;
      act_edge_q   <= (level != POL) && (prev_q == POL);
      inact_edge_q <= (level == POL) && (prev_q != POL);
    end
  end

  assign oActEdge   = act_edge_q;
  assign oInactEdge = inact_edge_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM decoder: measures active time and period in iCE ticks, strobes oValid per
// completed cycle and flags a stuck line. Optional input filter: PWM_CAPTURE_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int   TOTAL_BITS = CAP_TOTAL_BITS,
  parameter logic POL        = 1'b1
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iCE,
  input  logic              iPWM,
  output logic [TOTAL_BITS:0] ovActive,
  output logic [TOTAL_BITS:0] ovPeriod,
  output logic              oValid,
  output logic              oTimeout
);

  localparam int W = cap_width(TOTAL_BITS);
  localparam logic [W-1:0] SAT  = {W{1'b1}};
  localparam logic [W-1:0] ZERO = {W{1'b0}};

  e_cap_state   state_q;
  logic [W-1:0] act_cnt_q, per_cnt_q;
  logic [W-1:0] active_q, period_q;
  logic         valid_q, timeout_q;
  logic         act_edge, inact_edge;
  logic [W-1:0] first_cnt;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == SAT) ? v : v + 1'b1;
  endfunction

  pwm_edge_sync #(
    .POL(POL)
  ) u_edge_sync (
    .iClk      (iClk),
    .iRst      (iRst),
    .iLine     (iPWM),
    .oActEdge  (act_edge),
    .oInactEdge(inact_edge)
  );

  // A tick coinciding with an active edge belongs to the new cycle.
  assign first_cnt = {{(W-1){1'b0}}, iCE};

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= IDLE;
      act_cnt_q <= ZERO;
      per_cnt_q <= ZERO;
      active_q  <= ZERO;
      period_q  <= ZERO;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (act_edge) begin
            state_q   <= ACTIVE;
            act_cnt_q <= first_cnt;
            per_cnt_q <= first_cnt;
            timeout_q <= 1'b0;
          end
        end
        ACTIVE: begin
          if (per_cnt_q == SAT) begin
            state_q   <= IDLE;
            active_q  <= SAT;
            period_q  <= ZERO;
            valid_q   <= 1'b1;
            timeout_q <= 1'b1;
          end else if (inact_edge) begin
            state_q <= INACTIVE;
            if (iCE) per_cnt_q <= sat_inc(per_cnt_q);
          end else if (iCE) begin
            act_cnt_q <= sat_inc(act_cnt_q);
            per_cnt_q <= sat_inc(per_cnt_q);
          end
        end
        INACTIVE: begin
          if (per_cnt_q == SAT) begin
            state_q   <= IDLE;
            active_q  <= ZERO;
            period_q  <= ZERO;
            valid_q   <= 1'b1;
            timeout_q <= 1'b1;
          end else if (act_edge) begin
            state_q   <= ACTIVE;
            active_q  <= act_cnt_q;
            period_q  <= per_cnt_q;
            valid_q   <= 1'b1;
            act_cnt_q <= first_cnt;
            per_cnt_q <= first_cnt;
          end else if (iCE) begin
            per_cnt_q <= sat_inc(per_cnt_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ovActive = active_q;
  assign ovPeriod = period_q;
  assign oValid   = valid_q;
  assign oTimeout = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: random PWM cycles, stuck-line timeouts,
// sparse iCE, mid-measurement reset, and a glitch case when the filter is built in.
module tb_pwm_capture;

  localparam int   TB = 8;
  localparam logic POL = 1'b1;
  localparam logic ACT = ~POL;

  logic          iClk, iRst, iCE, iPWM;
  logic [TB:0]   ovActive, ovPeriod;
  logic          oValid, oTimeout;

  typedef struct {
    logic [TB:0] act;
    logic [TB:0] per;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ce_mode = 0;
  int   ce_cnt = 0;
  bit   armed = 0;
  int   prev_act, prev_per;

  pwm_capture #(.TOTAL_BITS(TB), .POL(POL)) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iCE     (iCE),
    .iPWM    (iPWM),
    .ovActive(ovActive),
    .ovPeriod(ovPeriod),
    .oValid  (oValid),
    .oTimeout(oTimeout)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Tick enable: every clock, or one clock in four.
  initial begin
    iCE = 1'b1;
    forever begin
      @(posedge iClk);
      #1;
      ce_cnt++;
      iCE = (ce_mode == 0) ? 1'b1 : ((ce_cnt % 4) == 0);
    end
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish within 60000 clocks");
    $fatal(1, "watchdog");
  end

  always @(negedge iClk) begin
    if (!iRst && oValid) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: act=%0d per=%0d tmo=%0b, no result expected",
                 ovActive, ovPeriod, oTimeout);
      end else begin
        e = exp_q.pop_front();
        if (ovActive !== e.act || ovPeriod !== e.per || oTimeout !== e.tmo) begin
          errors++;
          $display("FAIL result: got act=%0d per=%0d tmo=%0b, expected act=%0d per=%0d tmo=%0b",
                   ovActive, ovPeriod, oTimeout, e.act, e.per, e.tmo);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic push(input int a, input int p, input logic t);
    exp_t e;
    e.act = a[TB:0];
    e.per = p[TB:0];
    e.tmo = t;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic lvl, input int n);
    iPWM = lvl;
    repeat (n) begin
      @(posedge iClk);
      #1;
    end
  endtask

  // Model: a cycle is reported when the next active edge arrives; its counts
  // are the ticks spent active and the ticks from active edge to active edge.
  function automatic int ticks(input int clocks);
    return (ce_mode == 0) ? clocks : clocks / 4;
  endfunction

  task automatic cyc(input int a, input int i);
    if (armed) push(prev_act, prev_per, 1'b0);
    hold(ACT, a);
    hold(POL, i);
    prev_act = ticks(a);
    prev_per = ticks(a + i);
    armed = 1;
  endtask

  task automatic rand_cyc();
    if (ce_mode == 0) cyc($urandom_range(200, 2), $urandom_range(200, 2));
    else cyc(4 * $urandom_range(40, 1), 4 * $urandom_range(40, 1));
  endtask

  task automatic stuck_inactive(input int n);
    push(0, 0, 1'b1);
    hold(POL, n);
    armed = 0;
  endtask

  task automatic stuck_active(input int n);
    if (armed) push(prev_act, prev_per, 1'b0);
    push(511, 0, 1'b1);
    hold(ACT, n);
    armed = 0;
  endtask

`ifdef PWM_CAPTURE_FILTER_EN
  task automatic cyc_glitch(input int a, input int i1, input int i2);
    if (armed) push(prev_act, prev_per, 1'b0);
    hold(ACT, a);
    hold(POL, i1);
    hold(ACT, 1);
    hold(POL, i2);
    prev_act = ticks(a);
    prev_per = ticks(a + i1 + 1 + i2);
    armed = 1;
  endtask
`endif

  initial begin
    iRst = 1'b1;
    iPWM = POL;
    repeat (3) @(posedge iClk);
    #1;
    check("reset_active", int'(ovActive), 0);
    check("reset_period", int'(ovPeriod), 0);
    check("reset_valid", int'(oValid), 0);
    check("reset_timeout", int'(oTimeout), 0);
    iRst = 1'b0;
    hold(POL, 5);

    // Generator-like duty 64, then duty 200, full-rate ticks.
    repeat (4) cyc(64, 192);
    repeat (3) cyc(200, 56);
    repeat (15) rand_cyc();

    stuck_inactive(600);
    check("timeout_set_inactive", int'(oTimeout), 1);
    repeat (3) rand_cyc();
    check("timeout_cleared", int'(oTimeout), 0);

    stuck_active(600);
    check("timeout_set_active", int'(oTimeout), 1);
    hold(POL, 10);

    // One tick in four: duty 10 of a 256-tick period spans 1024 clocks.
    ce_mode = 1;
    repeat (3) cyc(40, 984);
    repeat (5) rand_cyc();
    stuck_inactive(2100);
    check("timeout_sparse_ce", int'(oTimeout), 1);
    ce_mode = 0;
    hold(POL, 10);

`ifdef PWM_CAPTURE_FILTER_EN
    repeat (2) cyc(64, 192);
    repeat (3) cyc_glitch($urandom_range(100, 2), $urandom_range(80, 2), $urandom_range(80, 2));
    cyc(64, 192);
`endif

    // Reset in the middle of an active phase.
    repeat (3) rand_cyc();
    if (armed) push(prev_act, prev_per, 1'b0);
    hold(ACT, 20);
    check("pending_before_reset", exp_q.size(), 0);
    iRst = 1'b1;
    #1;
    check("midrst_active", int'(ovActive), 0);
    check("midrst_period", int'(ovPeriod), 0);
    check("midrst_valid", int'(oValid), 0);
    check("midrst_timeout", int'(oTimeout), 0);
    armed = 0;
    hold(POL, 5);
    iRst = 1'b0;
    hold(POL, 5);
    repeat (4) rand_cyc();

    // Close the last cycle and let every expected result drain.
    if (armed) push(prev_act, prev_per, 1'b0);
    hold(ACT, 20);
    hold(POL, 20);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
